// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - Shared state and mode types for the SPI master
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LEAD,
        XFER,
        TRAIL
    } spi_state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
        logic lsb_first;
    } spi_mode_t;

endpackage

// File: rtl/spi_clkgen.sv
// rtl/spi_clkgen.sv - SCLK divider: tick every DIV cycles, leading/trailing edge flags, sclk register
module spi_clkgen #(
    parameter int DIV = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic run,
    input  logic toggle,
    input  logic cpol,
    output logic edge_tick,
    output logic lead,
    output logic trail,
    output logic sclk
);

    localparam int CW = $clog2(DIV + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sclk_q, sclk_d;

    assign edge_tick = run && (cnt_q == CW'(DIV - 1));
    // A toggle away from the idle level is a leading edge.
    assign lead      = (sclk_q == cpol);
    assign trail     = ~lead;
    assign sclk      = sclk_q;

    always_comb begin
        cnt_d  = cnt_q + CW'(1);
        sclk_d = sclk_q;
        if (!run || edge_tick) begin
            cnt_d = '0;
        end
        if (start) begin
            sclk_d = cpol;
        end else if (toggle) begin
            sclk_d = ~sclk_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

endmodule

// File: rtl/spi_master_multi.sv
// rtl/spi_master_multi.sv - Full-duplex SPI master, all CPOL/CPHA modes, selectable bit order, one-hot active-low selects
module spi_master_multi
    import spi_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int NUM_SS = 4,
    parameter int DIV    = 4,
    parameter int SEL_W  = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [SEL_W-1:0]  tx_sel,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_SS-1:0] ss_n
);

    localparam int            BW       = $clog2(2 * DATA_W + 1);
    localparam logic [BW-1:0] LAST_TOG = BW'(2 * DATA_W - 1);

    spi_state_t        state_q, state_d;
    spi_mode_t         mode_q, mode_d;
    logic [BW-1:0]     tog_q, tog_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
    logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              mosi_q, mosi_d;
    logic [NUM_SS-1:0] ss_n_q, ss_n_d;
    logic [NUM_SS-1:0] sel_ss_n;
    logic              accept, edge_tick, lead, trail;
    logic              do_shift, do_sample;

    assign accept   = tx_valid && (state_q == IDLE);
    assign tx_ready = (state_q == IDLE);
    assign busy     = ~tx_ready;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign mosi     = mosi_q;
    assign ss_n     = ss_n_q;

    spi_clkgen #(.DIV(DIV)) u_clkgen (
        .clock     (clock),
        .reset     (reset),
        .start     (accept),
        .run       (state_q != IDLE),
        .toggle    (edge_tick && (state_q == XFER)),
        .cpol      (accept ? cpol : mode_q.cpol),
        .edge_tick (edge_tick),
        .lead      (lead),
        .trail     (trail),
        .sclk      (sclk)
    );

    // Out-of-range selects decode to no active line; the frame still runs.
    always_comb begin
        sel_ss_n = '1;
        for (int i = 0; i < NUM_SS; i++) begin
            if (int'(tx_sel) == i) begin
                sel_ss_n[i] = 1'b0;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        tog_d      = tog_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        mosi_d     = mosi_q;
        ss_n_d     = ss_n_q;
        do_shift   = 1'b0;
        do_sample  = 1'b0;

        case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    state_d          = LEAD;
                    mode_d.cpol      = cpol;
                    mode_d.cpha      = cpha;
                    mode_d.lsb_first = lsb_first;
                    tx_sh_d          = tx_data;
                    tog_d            = '0;
                    mosi_d           = lsb_first ? tx_data[0] : tx_data[DATA_W-1];
                    ss_n_d           = sel_ss_n;
                end
            end
            LEAD: begin
                if (edge_tick) begin
                    state_d = XFER;
                end
            end
            XFER: begin
                if (edge_tick) begin
                    tog_d = tog_q + BW'(1);
                    if (tog_q == LAST_TOG) begin
                        state_d = TRAIL;
                    end
                    // CPHA=1 already shows bit 0 from LEAD, so its first leading edge does not shift.
                    if (mode_q.cpha) begin
                        do_shift  = lead && (tog_q != '0);
                        do_sample = trail;
                    end else begin
                        do_shift  = trail && (tog_q != LAST_TOG);
                        do_sample = lead;
                    end
                end
            end
            TRAIL: begin
                if (edge_tick) begin
                    state_d    = IDLE;
                    ss_n_d     = '1;
                    rx_valid_d = 1'b1;
                    rx_data_d  = rx_sh_q;
                    mosi_d     = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_shift) begin
            tx_sh_d = mode_q.lsb_first ? (tx_sh_q >> 1) : (tx_sh_q << 1);
            mosi_d  = mode_q.lsb_first ? tx_sh_d[0] : tx_sh_d[DATA_W-1];
        end
        if (do_sample) begin
            rx_sh_d = mode_q.lsb_first ? {miso, rx_sh_q[DATA_W-1:1]}
                                       : {rx_sh_q[DATA_W-2:0], miso};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            mode_q     <= '0;
            tog_q      <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            mosi_q     <= 1'b0;
            ss_n_q     <= '1;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            tog_q      <= tog_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            mosi_q     <= mosi_d;
            ss_n_q     <= ss_n_d;
        end
    end

endmodule

// File: tb/tb_spi_master_multi.sv
// tb/tb_spi_master_multi.sv - Self-checking bench for spi_master_multi across three parameterisations
module tb_spi_master_multi;

    typedef struct {
        int           which;
        bit           pol;
        bit           pha;
        bit           lf;
        logic [63:0]  d;
        logic [2:0]   sel;
        logic [63:0]  sw;
        logic [63:0]  exp_rx;
        logic [7:0]   exp_ss;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        tx_valid;
    logic [63:0] tx_data;
    logic [2:0]  tx_sel;
    logic        cpol, cpha, lsb;
    int          act = 0;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    logic        ready_a, rxv_a, busy_a, sclk_a, mosi_a;
    logic [7:0]  rxd_a;
    logic [3:0]  ss_a;
    logic        ready_b, rxv_b, busy_b, sclk_b, mosi_b;
    logic [63:0] rxd_b;
    logic [3:0]  ss_b;
    logic        ready_c, rxv_c, busy_c, sclk_c, mosi_c;
    logic [7:0]  rxd_c;
    logic [4:0]  ss_c;

    logic        mx_ready, mx_rxv, mx_busy, mx_sclk, mx_mosi;
    logic [63:0] mx_rxd;
    logic [7:0]  mx_ss;

    logic        miso_m = 1'b0;
    logic [63:0] slave_word = '0;
    bit          cur_pha = 1'b0;
    bit          cur_lf = 1'b0;
    int          cur_dw = 8;
    bit          prev_busy = 1'b0;
    bit          prev_sclk = 1'b0;
    int          edge_n = 0;
    bit          got[$];
    vec_t        tbl[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_master_multi #(.DATA_W(8), .NUM_SS(4), .DIV(2)) u_a (
        .clock(clk), .reset(rst), .tx_valid(tx_valid && act == 0), .tx_ready(ready_a),
        .tx_data(tx_data[7:0]), .tx_sel(tx_sel[1:0]), .cpol(cpol), .cpha(cpha), .lsb_first(lsb),
        .rx_valid(rxv_a), .rx_data(rxd_a), .busy(busy_a), .sclk(sclk_a), .mosi(mosi_a),
        .miso(miso_m), .ss_n(ss_a)
    );

    spi_master_multi #(.DATA_W(64), .NUM_SS(4), .DIV(1)) u_b (
        .clock(clk), .reset(rst), .tx_valid(tx_valid && act == 1), .tx_ready(ready_b),
        .tx_data(tx_data), .tx_sel(tx_sel[1:0]), .cpol(cpol), .cpha(cpha), .lsb_first(lsb),
        .rx_valid(rxv_b), .rx_data(rxd_b), .busy(busy_b), .sclk(sclk_b), .mosi(mosi_b),
        .miso(mosi_b), .ss_n(ss_b)
    );

    spi_master_multi #(.DATA_W(8), .NUM_SS(5), .DIV(3)) u_c (
        .clock(clk), .reset(rst), .tx_valid(tx_valid && act == 2), .tx_ready(ready_c),
        .tx_data(tx_data[7:0]), .tx_sel(tx_sel), .cpol(cpol), .cpha(cpha), .lsb_first(lsb),
        .rx_valid(rxv_c), .rx_data(rxd_c), .busy(busy_c), .sclk(sclk_c), .mosi(mosi_c),
        .miso(1'b1), .ss_n(ss_c)
    );

    always_comb begin
        mx_ready = ready_a; mx_rxv = rxv_a; mx_busy = busy_a; mx_sclk = sclk_a;
        mx_mosi = mosi_a; mx_rxd = 64'(rxd_a); mx_ss = {4'hF, ss_a};
        if (act == 1) begin
            mx_ready = ready_b; mx_rxv = rxv_b; mx_busy = busy_b; mx_sclk = sclk_b;
            mx_mosi = mosi_b; mx_rxd = rxd_b; mx_ss = {4'hF, ss_b};
        end else if (act == 2) begin
            mx_ready = ready_c; mx_rxv = rxv_c; mx_busy = busy_c; mx_sclk = sclk_c;
            mx_mosi = mosi_c; mx_rxd = 64'(rxd_c); mx_ss = {3'h7, ss_c};
        end
    end

    function automatic logic sbit(int i);
        return cur_lf ? slave_word[i] : slave_word[cur_dw-1-i];
    endfunction

    // Slave: records mosi on its sampling edges and presents its own word on miso in protocol order.
    always @(negedge clk) begin
        if (mx_busy && !prev_busy) begin
            edge_n = 0;
            got.delete();
            miso_m = sbit(0);
        end else if (mx_busy && mx_sclk != prev_sclk) begin
            edge_n = edge_n + 1;
            if ((edge_n % 2 == 1) != cur_pha) got.push_back(mx_mosi);
            if (!cur_pha && edge_n % 2 == 0 && edge_n < 2 * cur_dw) miso_m = sbit(edge_n / 2);
            if (cur_pha && edge_n % 2 == 1) miso_m = sbit((edge_n - 1) / 2);
        end
        prev_busy = mx_busy;
        prev_sclk = mx_sclk;
    end

    function automatic logic [63:0] got_word(int dw, bit lf);
        logic [63:0] w = '0;
        for (int i = 0; i < got.size() && i < dw; i++) w[lf ? i : dw-1-i] = got[i];
        return w;
    endfunction

    task automatic check(input string name, input logic [63:0] got_v, input logic [63:0] exp_v);
        n_tests++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got_v, exp_v);
        end
    endtask

    task automatic wait_rx(input int bound, output bit done);
        done = 1'b0;
        for (int t = 0; t < bound && !done; t++) begin
            if (mx_rxv) done = 1'b1;
            else @(negedge clk);
        end
    endtask

    function automatic vec_t mk(int w, bit p, bit h, bit l, logic [63:0] d, logic [2:0] s,
                                logic [63:0] sw, logic [63:0] er, logic [7:0] es);
        vec_t v;
        v.which = w; v.pol = p; v.pha = h; v.lf = l; v.d = d; v.sel = s;
        v.sw = sw; v.exp_rx = er; v.exp_ss = es;
        return v;
    endfunction

    task automatic set_mode(input int which, input bit p, input bit h, input bit l);
        act = which; cpol = p; cpha = h; lsb = l;
        cur_pha = h; cur_lf = l; cur_dw = (which == 1) ? 64 : 8;
    endtask

    task automatic run_frame(input vec_t v);
        int          e0, lowc, dw, dv, t;
        logic [7:0]  ss_and;
        logic [63:0] dmask;
        bit          done;
        dw = (v.which == 1) ? 64 : 8;
        dv = (v.which == 0) ? 2 : (v.which == 1) ? 1 : 3;
        set_mode(v.which, v.pol, v.pha, v.lf);
        slave_word = v.sw; tx_data = v.d; tx_sel = v.sel; tx_valid = 1'b1;
        #1;
        t = 0;
        while (!mx_ready && t < 50) begin @(negedge clk); t++; end
        check("accept", 64'(mx_ready), 64'd1);
        e0 = cyc + 1;
        @(negedge clk);
        tx_valid = 1'b0;
        check("lead_sclk", 64'(mx_sclk), 64'(v.pol));
        ss_and = '1; lowc = 0; done = 1'b0;
        for (t = 0; t < 400 && !done; t++) begin
            ss_and &= mx_ss;
            if (mx_ss != 8'hFF) lowc++;
            if (mx_rxv) done = 1'b1;
            else @(negedge clk);
        end
        dmask = (dw == 64) ? v.d : (v.d & 64'hFF);
        check("rx_timeout", 64'(done), 64'd1);
        check("latency", 64'(cyc - e0), 64'((2 * dw + 2) * dv));
        check("rx_data", mx_rxd, v.exp_rx);
        check("ready_at_rx", 64'(mx_ready), 64'd1);
        check("ss_low_cycles", 64'(lowc), (v.exp_ss == 8'hFF) ? 64'd0 : 64'((2 * dw + 2) * dv));
        check("ss_pattern", 64'(ss_and), 64'(v.exp_ss));
        check("sclk_edges", 64'(edge_n), 64'(2 * dw));
        check("mosi_bits", 64'(got.size()), 64'(dw));
        check("mosi_word", got_word(dw, v.lf), dmask);
        @(negedge clk);
        check("idle_sclk", 64'(mx_sclk), 64'(v.pol));
        check("rx_pulse_1cyc", 64'(mx_rxv), 64'd0);
        check("idle_mosi", 64'(mx_mosi), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          e0, cnt;
        bit          done;
        logic [63:0] r64;
        logic [2:0]  rs;
        rst = 1'b1; tx_valid = 1'b0; tx_data = '0; tx_sel = '0; cpol = 1'b0; cpha = 1'b0; lsb = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(mx_ready), 64'd1);
        check("rst_busy", 64'(mx_busy), 64'd0);
        check("rst_rx_valid", 64'(mx_rxv), 64'd0);
        check("rst_rx_data", mx_rxd, 64'd0);
        check("rst_sclk", 64'(mx_sclk), 64'd0);
        check("rst_mosi", 64'(mx_mosi), 64'd0);
        check("rst_ss_n", 64'(mx_ss), 64'hFF);
        rst = 1'b0;
        @(negedge clk);

        tbl.push_back(mk(0, 0, 0, 0, 64'hA5, 3'd2, 64'h3C, 64'h3C, 8'hFB));
        for (int m = 0; m < 4; m++)
            tbl.push_back(mk(0, m[1], m[0], 1, 64'hA5, 3'd2, 64'h3C, 64'h3C, 8'hFB));
        tbl.push_back(mk(2, 0, 0, 0, 64'h5A, 3'd5, 64'h0, 64'hFF, 8'hFF));
        tbl.push_back(mk(2, 1, 1, 1, 64'h96, 3'd7, 64'h0, 64'hFF, 8'hFF));
        tbl.push_back(mk(2, 0, 1, 0, 64'h11, 3'd4, 64'h0, 64'hFF, 8'hEF));
        tbl.push_back(mk(1, 0, 0, 0, 64'hDEADBEEF_01234567, 3'd0, 64'h0, 64'hDEADBEEF_01234567, 8'hFE));
        r64 = {$urandom, $urandom};
        tbl.push_back(mk(1, 1, 1, 1, r64, 3'd3, 64'h0, r64, 8'hF7));
        for (int k = 0; k < 6; k++) begin
            rs  = 3'($urandom_range(0, 3));
            r64 = 64'($urandom_range(0, 255));
            tbl.push_back(mk(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                             1'($urandom_range(0, 1)), 64'($urandom_range(0, 255)), rs,
                             r64, r64, ~(8'd1 << rs)));
        end
        foreach (tbl[i]) run_frame(tbl[i]);

        // Back-to-back: second command held valid and taken in the rx_valid cycle.
        set_mode(0, 0, 0, 0);
        slave_word = 64'h5A; tx_data = 64'h01; tx_sel = 3'd0; tx_valid = 1'b1;
        #1;
        check("b2b_accept", 64'(mx_ready), 64'd1);
        e0 = cyc + 1;
        @(negedge clk);
        tx_data = 64'hFF;
        wait_rx(200, done);
        check("b2b_rx1_seen", 64'(done), 64'd1);
        check("b2b_lat1", 64'(cyc - e0), 64'd36);
        check("b2b_rx1", mx_rxd, 64'h5A);
        check("b2b_mosi1", got_word(8, 0), 64'h01);
        check("b2b_ss_gap", 64'(mx_ss), 64'hFF);
        check("b2b_ready", 64'(mx_ready), 64'd1);
        e0 = cyc + 1;
        @(negedge clk);
        tx_valid = 1'b0;
        check("b2b_ss_reassert", 64'(mx_ss), 64'hFE);
        wait_rx(200, done);
        check("b2b_rx2_seen", 64'(done), 64'd1);
        check("b2b_lat2", 64'(cyc - e0), 64'd36);
        check("b2b_rx2", mx_rxd, 64'h5A);
        check("b2b_mosi2", got_word(8, 0), 64'hFF);
        @(negedge clk);

        // Reset in the middle of XFER.
        set_mode(0, 1, 0, 0);
        slave_word = 64'h81; tx_data = 64'hC3; tx_sel = 3'd1; tx_valid = 1'b1;
        #1;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (11) @(negedge clk);
        check("mid_busy", 64'(mx_busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_ss_n", 64'(mx_ss), 64'hFF);
        check("mid_rst_sclk", 64'(mx_sclk), 64'd0);
        check("mid_rst_ready", 64'(mx_ready), 64'd1);
        check("mid_rst_rx_valid", 64'(mx_rxv), 64'd0);
        check("mid_rst_rx_data", mx_rxd, 64'd0);
        check("mid_rst_mosi", 64'(mx_mosi), 64'd0);
        rst = 1'b0;
        cnt = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (mx_rxv) cnt++;
        end
        check("mid_no_rx_pulse", 64'(cnt), 64'd0);
        run_frame(mk(0, 1, 0, 0, 64'hC3, 3'd1, 64'h81, 64'h81, 8'hFD));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
